// File: rtl/shifter_issue_ctrl.sv
// Issue/capture stage around a combinational 32-bit rotate-right shifter:
// queues requests, drives them one at a time from registers, waits, then captures.
module shifter_issue_ctrl #(
  parameter  int FIFO_DEPTH    = 4,
  parameter  int SETTLE_CYCLES = 1,
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_amt,
  output logic [31:0]      sh_data,
  output logic [4:0]       sh_amt,
  input  logic [31:0]      sh_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_amt,
  output logic [CNT_W-1:0] fifo_level,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [4:0]  amt;
    logic [31:0] data;
  } req_t;

  req_t             mem [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] level_reg;
  logic [SET_W-1:0] cnt_reg;
  state_t           state_reg;
  logic             push;
  logic             pop;

  assign in_ready   = (level_reg < CNT_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  // A pop happens only when the FSM is ready to launch the next request.
  assign pop        = (level_reg != '0) &&
                      ((state_reg == IDLE) || ((state_reg == HOLD) && out_ready));
  assign head       = mem[rd_ptr_reg];
  assign fifo_level = level_reg;
  assign busy       = (state_reg != IDLE) || (level_reg != '0);

  // Storage has no reset; only the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= '{amt: in_amt, data: in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + CNT_W'(1);
        2'b01:   level_reg <= level_reg - CNT_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sh_data   <= '0;
      sh_amt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            sh_data   <= head.data;
            sh_amt    <= head.amt;
            cnt_reg   <= SET_W'(SETTLE_CYCLES - 1);
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) begin
            out_data  <= sh_out;
            out_amt   <= sh_amt;
            out_valid <= 1'b1;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - SET_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Launch the next request in the same cycle the result is taken.
            if (pop) begin
              sh_data   <= head.data;
              sh_amt    <= head.amt;
              cnt_reg   <= SET_W'(SETTLE_CYCLES - 1);
              state_reg <= SETTLE;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_issue_ctrl.sv
// Directed bench for shifter_issue_ctrl: scoreboard of expected results,
// behavioural rotate model on the shifter side, second instance with SETTLE_CYCLES=3.
module tb_shifter_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, sh_data, sh_out, out_data;
  logic [4:0]  in_amt, sh_amt, out_amt;
  logic [2:0]  fifo_level;

  logic        in_valid_s3, in_ready_s3, out_valid_s3, out_ready_s3, busy_s3;
  logic [31:0] in_data_s3, sh_data_s3, sh_out_s3, out_data_s3;
  logic [4:0]  in_amt_s3, sh_amt_s3, out_amt_s3;
  logic [2:0]  fifo_level_s3;

  function automatic logic [31:0] rotr(input logic [31:0] d, input logic [4:0] a);
    logic [63:0] w;
    w = {d, d} >> a;
    return w[31:0];
  endfunction

  assign sh_out = rotr(sh_data, sh_amt);

  shifter_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .sh_data(sh_data), .sh_amt(sh_amt),
    .sh_out(sh_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_amt(out_amt), .fifo_level(fifo_level), .busy(busy)
  );

  shifter_issue_ctrl #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s3), .in_ready(in_ready_s3),
    .in_data(in_data_s3), .in_amt(in_amt_s3), .sh_data(sh_data_s3), .sh_amt(sh_amt_s3),
    .sh_out(sh_out_s3), .out_valid(out_valid_s3), .out_ready(out_ready_s3),
    .out_data(out_data_s3), .out_amt(out_amt_s3), .fifo_level(fifo_level_s3), .busy(busy_s3)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  a;
  } exp_t;

  exp_t        exp_q[$];
  int          out_cyc_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          accepted;
  logic [31:0] cur_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Records handshakes about to happen on the next edge, then advances one cycle.
  task automatic tick();
    exp_t e;
    accepted = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(exp_t'({cur_exp, in_amt}));
      accepted = 1'b1;
    end
    if (out_valid && out_ready) begin
      n_out++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("out #%0d: data=0x%08h amt=%0d (exp 0x%08h/%0d)", n_out, out_data, out_amt, e.d, e.a);
        chk("sb_data", out_data, e.d);
        chk("sb_amt", 32'(out_amt), 32'(e.a));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic [31:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    cur_exp  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] t2_amt [4] = '{32'd0, 32'd2, 32'd30, 32'd31};
  logic [31:0] t2_exp [4] = '{32'h00000003, 32'hC0000000, 32'h0000000C, 32'h00000006};

  initial begin
    int          lat;
    int          n0;
    int          idx;
    int          k;
    logic [31:0] held;
    logic [31:0] d;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1; cur_exp = '0;
    in_valid_s3 = 1'b0; in_data_s3 = '0; in_amt_s3 = '0; out_ready_s3 = 1'b1;
    sh_out_s3 = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_sh_data", sh_data, 32'd0);
    chk("rst_sh_amt", 32'(sh_amt), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_amt", 32'(out_amt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request latency
    drive(32'h00000003, 5'd1, 32'h80000001);
    tick();
    chk("t1_accept", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_out_data", out_data, 32'h80000001);
    chk("t1_out_amt", 32'(out_amt), 32'd1);
    tick();
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Back-to-back stream
    n0 = n_out;
    out_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(32'h00000003, t2_amt[i][4:0], t2_exp[i]);
      tick();
      chk("t2_accept", 32'(accepted), 32'd1);
    end
    in_valid = 1'b0;
    k = 0;
    while (n_out - n0 < 4 && k < 40) begin
      tick();
      k++;
    end
    chk("t2_count", 32'(n_out - n0), 32'd4);
    for (int i = 1; i < out_cyc_q.size(); i++) begin
      chk("t2_gap", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd2);
    end

    // Backpressure
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      drive(d, 5'(i * 7 + 3), rotr(d, 5'(i * 7 + 3)));
      tick();
      chk("t3_accept", 32'(accepted), 32'd1);
    end
    drive(32'hA5A5A5A5, 5'd9, rotr(32'hA5A5A5A5, 5'd9));
    held = exp_q[0].d;
    for (int i = 0; i < 3; i++) begin
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_level", 32'(fifo_level), 32'd4);
      chk("t3_out_valid", 32'(out_valid), 32'd1);
      chk("t3_out_stable", out_data, held);
      tick();
      chk("t3_no_accept", 32'(accepted), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 50) begin
      tick();
      k++;
    end
    chk("t3_drained", 32'(n_out - n0), 32'd5);

    // Pointer wrap with alternating out_ready
    n0 = n_out;
    idx = 0;
    k = 0;
    while ((idx < 10 || exp_q.size() != 0) && k < 200) begin
      out_ready = (k % 2 == 0);
      if (idx < 10) begin
        d = 32'h01000000 * 32'(idx + 1) + 32'(idx * 3 + 1);
        drive(d, 5'(idx * 5 + 1), rotr(d, 5'(idx * 5 + 1)));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (accepted) idx++;
      k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t4_count", 32'(n_out - n0), 32'd10);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset while SETTLE has two requests queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h00000010 << i, 5'(i + 4), rotr(32'h00000010 << i, 5'(i + 4)));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_pre_level", 32'(fifo_level), 32'd2);
    chk("t5_pre_sh_data", sh_data, 32'h00000020);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_sh_data", sh_data, 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive(32'h00000003, 5'd25, 32'h00000180);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk("t5_result", out_data, 32'h00000180);
    tick();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // SETTLE_CYCLES=3 instance, shifter output updated late
    in_valid_s3 = 1'b1;
    in_data_s3 = 32'h12345678;
    in_amt_s3 = 5'd13;
    chk("t6_in_ready", 32'(in_ready_s3), 32'd1);
    tick();
    in_valid_s3 = 1'b0;
    lat = 1;
    tick();
    lat++;
    chk("t6_sh_data", sh_data_s3, 32'h12345678);
    chk("t6_sh_amt", 32'(sh_amt_s3), 32'd13);
    while (!out_valid_s3 && lat < 20) begin
      tick();
      lat++;
      if (lat == 3) sh_out_s3 = rotr(32'h12345678, 5'd13);
    end
    $display("s3: latency=%0d data=0x%08h amt=%0d", lat, out_data_s3, out_amt_s3);
    chk("t6_latency", 32'(lat), 32'd5);
    chk("t6_out_data", out_data_s3, rotr(32'h12345678, 5'd13));
    chk("t6_out_amt", 32'(out_amt_s3), 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
